// File: rtl/data_field_if.sv
// Bundle of the data-field control and serial signals shared by the
// data_field serializer and whoever drives it.
interface data_field_if;
  logic        enable;
  logic        sample_point;
  logic        Tx_request;
  logic        control_complete;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data_in;
  logic        data_bit;
  logic [6:0]  bit_counter;
  logic        data_complete;

  modport master (
    output enable, sample_point, Tx_request, control_complete, rtr, dlc, data_in,
    input  data_bit, bit_counter, data_complete
  );

  modport slave (
    input  enable, sample_point, Tx_request, control_complete, rtr, dlc, data_in,
    output data_bit, bit_counter, data_complete
  );
endinterface

// File: rtl/data_field.sv
// CAN data-field serializer: shifts min(dlc,MAX_BYTES) payload bytes out MSB-first,
// one bit per sample_point, then flags data_complete until Tx_request drops.
module data_field #(
  parameter int MAX_BYTES = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  data_field_if.slave  dif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SHIFT    = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  localparam logic [3:0] MAX_DLC = 4'(MAX_BYTES);

  state_t      state_r, state_nxt_s;
  logic [63:0] shift_r, shift_nxt_s;
  logic [6:0]  bits_rem_r, bits_nxt_s;
  logic        rtr_r, rtr_nxt_s;
  logic        data_bit_r, data_bit_nxt_s;
  logic [6:0]  cnt_r, cnt_nxt_s;
  logic        done_r, done_nxt_s;
  logic        start_s;
  logic [3:0]  dlc_sat_s;

  assign start_s   = dif.enable & dif.Tx_request & dif.control_complete;
  assign dlc_sat_s = (dif.dlc > MAX_DLC) ? MAX_DLC : dif.dlc;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; enable low is the only abort path
  always_comb begin
    state_nxt_s = state_r;
    if (!dif.enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:     state_nxt_s = start_s ? LOAD : IDLE;
        LOAD:     state_nxt_s = (rtr_r || (bits_rem_r == 7'd0)) ? COMPLETE : SHIFT;
        SHIFT:    state_nxt_s = (dif.sample_point && (bits_rem_r == 7'd1)) ? COMPLETE : SHIFT;
        COMPLETE: state_nxt_s = dif.Tx_request ? COMPLETE : IDLE;
        default:  state_nxt_s = IDLE;
      endcase
    end
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    shift_nxt_s    = shift_r;
    bits_nxt_s     = bits_rem_r;
    rtr_nxt_s      = rtr_r;
    data_bit_nxt_s = data_bit_r;
    cnt_nxt_s      = cnt_r;
    done_nxt_s     = done_r;
    if (!dif.enable) begin
      shift_nxt_s    = 64'd0;
      bits_nxt_s     = 7'd0;
      rtr_nxt_s      = 1'b0;
      data_bit_nxt_s = 1'b1;
      cnt_nxt_s      = 7'd0;
      done_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          data_bit_nxt_s = 1'b1;
          cnt_nxt_s      = 7'd0;
          done_nxt_s     = 1'b0;
          // Payload, rtr and length are captured on the start edge so LOAD can decide
          if (start_s) begin
            shift_nxt_s = dif.data_in;
            rtr_nxt_s   = dif.rtr;
            bits_nxt_s  = {dlc_sat_s, 3'b000};
          end else begin
            shift_nxt_s = shift_r;
          end
        end
        LOAD: begin
          if (rtr_r || (bits_rem_r == 7'd0)) begin
            done_nxt_s     = 1'b1;
            data_bit_nxt_s = 1'b1;
          end else begin
            data_bit_nxt_s = shift_r[63];
          end
        end
        SHIFT: begin
          if (dif.sample_point) begin
            cnt_nxt_s = cnt_r + 7'd1;
            if (bits_rem_r == 7'd1) begin
              done_nxt_s     = 1'b1;
              data_bit_nxt_s = 1'b1;
            end else begin
              shift_nxt_s    = {shift_r[62:0], 1'b0};
              bits_nxt_s     = bits_rem_r - 7'd1;
              data_bit_nxt_s = shift_r[62];
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        COMPLETE: begin
          data_bit_nxt_s = 1'b1;
          if (!dif.Tx_request) begin
            done_nxt_s = 1'b0;
            cnt_nxt_s  = 7'd0;
          end else begin
            done_nxt_s = 1'b1;
          end
        end
        default: begin
          data_bit_nxt_s = 1'b1;
          cnt_nxt_s      = 7'd0;
          done_nxt_s     = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_r    <= 64'd0;
      bits_rem_r <= 7'd0;
      rtr_r      <= 1'b0;
      data_bit_r <= 1'b1;
      cnt_r      <= 7'd0;
      done_r     <= 1'b0;
    end else begin
      shift_r    <= shift_nxt_s;
      bits_rem_r <= bits_nxt_s;
      rtr_r      <= rtr_nxt_s;
      data_bit_r <= data_bit_nxt_s;
      cnt_r      <= cnt_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign dif.data_bit      = data_bit_r;
  assign dif.bit_counter   = cnt_r;
  assign dif.data_complete = done_r;

endmodule

// File: tb/tb_data_field.sv
// Scoreboard bench for data_field: a frame-level model queues the expected bit stream,
// a negedge monitor compares every counted bit and every completion.
module tb_data_field;

  typedef struct {
    logic b;
    int   cnt;
  } exp_bit_t;

  logic clock;
  logic reset_n;
  data_field_if dif ();

  data_field #(.MAX_BYTES(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dif     (dif)
  );

  int       vectors    = 0;
  int       miscompares = 0;
  exp_bit_t exp_bits[$];
  int       exp_done[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: a frame is just the top 8*min(dlc,8) bits of the payload, none for remote frames
  task automatic model_frame(input logic [3:0] d, input logic r, input logic [63:0] data, output int nb);
    exp_bit_t e;
    nb = r ? 0 : 8 * ((int'(d) > 8) ? 8 : int'(d));
    for (int i = 0; i < nb; i++) begin
      e.b   = data[63 - i];
      e.cnt = i + 1;
      exp_bits.push_back(e);
    end
    exp_done.push_back(nb);
  endtask

  // Monitor: a bit is consumed when bit_counter advances; the bit is what was shown at the pulse
  initial begin
    logic [6:0] prev_cnt;
    logic       prev_dc;
    logic       sp_bit;
    exp_bit_t   e;
    int         nd;
    prev_cnt = 7'd0;
    prev_dc  = 1'b0;
    sp_bit   = 1'b1;
    forever begin
      @(negedge clock);
      if ((dif.bit_counter != prev_cnt) && (dif.bit_counter != 7'd0)) begin
        if (exp_bits.size() == 0) begin
          check("unexpected_bit", 64'(dif.bit_counter), 64'd0);
        end else begin
          e = exp_bits.pop_front();
          check("data_bit", 64'(sp_bit), 64'(e.b));
          check("bit_counter", 64'(dif.bit_counter), 64'(e.cnt));
        end
      end
      if (dif.data_complete && !prev_dc) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'(dif.data_complete), 64'd0);
        end else begin
          nd = exp_done.pop_front();
          check("done_count", 64'(dif.bit_counter), 64'(nd));
          check("done_bit", 64'(dif.data_bit), 64'd1);
          check("bits_left_at_done", 64'(exp_bits.size()), 64'd0);
        end
      end
      if (dif.sample_point) sp_bit = dif.data_bit;
      prev_cnt = dif.bit_counter;
      prev_dc  = dif.data_complete;
    end
  end

  task automatic check_idle(input string name);
    check({name, "_bit"}, 64'(dif.data_bit), 64'd1);
    check({name, "_cnt"}, 64'(dif.bit_counter), 64'd0);
    check({name, "_done"}, 64'(dif.data_complete), 64'd0);
  endtask

  // abort_at: pulse count after which the frame is cut (0 = never); use_reset picks reset_n over enable
  task automatic run_frame(input logic [3:0] d, input logic r, input logic [63:0] data,
                           input int period, input int abort_at, input bit use_reset);
    int nb;
    model_frame(d, r, data, nb);
    dif.dlc              = d;
    dif.rtr              = r;
    dif.data_in          = data;
    dif.Tx_request       = 1'b1;
    dif.control_complete = 1'b1;
    tick();
    dif.control_complete = 1'b0;
    tick();
    @(negedge clock);
    if (nb == 0) begin
      check("zero_len_done", 64'(dif.data_complete), 64'd1);
      check("zero_len_cnt", 64'(dif.bit_counter), 64'd0);
      check("zero_len_bit", 64'(dif.data_bit), 64'd1);
    end else begin
      check("first_bit", 64'(dif.data_bit), 64'(data[63]));
      check("early_done", 64'(dif.data_complete), 64'd0);
    end
    for (int k = 1; k <= nb; k++) begin
      repeat (period - 1) tick();
      dif.sample_point = 1'b1;
      tick();
      dif.sample_point = 1'b0;
      if (k == abort_at) begin
        @(negedge clock);
        check("queue_at_abort", 64'(exp_bits.size()), 64'(nb - k));
        exp_bits.delete();
        exp_done.delete();
        if (use_reset) begin
          #1 reset_n = 1'b0;
          #1 check_idle("async_reset");
          tick();
          reset_n        = 1'b1;
          dif.Tx_request = 1'b0;
          tick();
        end else begin
          tick();
          dif.enable = 1'b0;
          tick();
          @(negedge clock);
          check_idle("abort_idle");
          tick();
          dif.enable     = 1'b1;
          dif.Tx_request = 1'b0;
          tick();
        end
        return;
      end
    end
    if (nb > 0) begin
      @(negedge clock);
      check("done_timing", 64'(dif.data_complete), 64'd1);
      check("final_count", 64'(dif.bit_counter), 64'(nb));
    end
    tick();
    dif.Tx_request = 1'b0;
    tick();
    @(negedge clock);
    check_idle("release");
    tick();
  endtask

  initial begin
    logic [3:0]  d;
    logic        r;
    logic [63:0] data;
    reset_n              = 1'b0;
    dif.enable           = 1'b1;
    dif.sample_point     = 1'b0;
    dif.Tx_request       = 1'b0;
    dif.control_complete = 1'b0;
    dif.rtr              = 1'b0;
    dif.dlc              = 4'd0;
    dif.data_in          = 64'd0;
    tick();
    @(negedge clock);
    check_idle("reset");
    tick();
    reset_n = 1'b1;
    tick();

    run_frame(4'd1, 1'b0, 64'hA500_0000_0000_0000, 5, 0, 1'b0);
    run_frame(4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 1'b0);
    run_frame(4'd8, 1'b0, 64'h0123_4567_89AB_CDEF, 3, 0, 1'b0);
    run_frame(4'd15, 1'b0, 64'h0123_4567_89AB_CDEF, 3, 0, 1'b0);
    run_frame(4'd8, 1'b1, 64'h0123_4567_89AB_CDEF, 3, 0, 1'b0);
    run_frame(4'd2, 1'b0, 64'hC3A1_0000_0000_0000, 4, 5, 1'b0);
    run_frame(4'd2, 1'b0, 64'hC3A1_0000_0000_0000, 4, 0, 1'b0);
    run_frame(4'd4, 1'b0, 64'h5A3C_96E1_0000_0000, 3, 10, 1'b1);
    run_frame(4'd4, 1'b0, 64'h5A3C_96E1_0000_0000, 3, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      d    = 4'($urandom_range(0, 15));
      r    = ($urandom_range(0, 3) == 0);
      data = {32'($urandom), 32'($urandom)};
      run_frame(d, r, data, int'($urandom_range(3, 6)), 0, 1'b0);
    end

    check("leftover_bits", 64'(exp_bits.size()), 64'd0);
    check("leftover_done", 64'(exp_done.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_field.md
# data_field

Serializes the CAN data field, the stage directly downstream of `control_field`. It starts once `control_complete` is asserted for a pending transmit request. It then shifts out `min(dlc,8)` bytes of payload MSB-first, one bit per `sample_point`. When the payload is exhausted it raises `data_complete` to the CRC stage. Remote frames and DLC 0 produce no data bits and complete immediately.

## Interface
Parameters:
- `MAX_BYTES`, default 8: payload capacity in bytes. DLC values above this saturate to it.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock; all state changes on its rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `enable`  in  1  block enable; low forces IDLE synchronously
- `sample_point`  in  1  one-clock pulse marking a bit boundary, from bit timing
- `Tx_request`  in  1  frame transmission pending
- `control_complete`  in  1  control field finished; triggers start
- `rtr`  in  1  remote frame flag; sampled at start
- `dlc`  in  4  data length code; sampled at start
- `data_in`  in  64  payload; byte 0 in [63:56], byte 7 in [7:0]; sampled at start
- `data_bit`  out  1  current serial bit; 1 (recessive) when not shifting
- `bit_counter`  out  7  data bits already consumed in this frame, 0..64
- `data_complete`  out  1  data field finished; held until release

## Operation
- States:
  - IDLE:
    - `data_bit`=1, `bit_counter`=0, `data_complete`=0.
    - Leaves to LOAD when `enable & Tx_request & control_complete`.
  - LOAD (one cycle):
    - Captures `data_in` into a 64-bit shift register.
    - Captures `rtr` into a latched copy.
    - Sets `bits_remaining` = 8 × min(`dlc`, `MAX_BYTES`), width 7.
  - After LOAD:
    - If the latched `rtr` is set or `bits_remaining`==0, go to COMPLETE.
    - Otherwise go to SHIFT, with `data_bit` = shift register [63].
  - SHIFT, on each cycle where `sample_point` is high:
    - `bit_counter` increments.
    - If `bits_remaining`==1, go to COMPLETE.
    - Otherwise shift the register left by one, decrement `bits_remaining`, and set `data_bit` to the new [63].
  - SHIFT, on cycles without `sample_point`: all state holds.
  - COMPLETE:
    - `data_complete`=1, `data_bit`=1, `bit_counter` holds its final value.
    - Returns to IDLE when `Tx_request`=0.
- Arithmetic:
  - `dlc` values 9..15 count as 8 (CAN 2.0 rule).
  - `bits_remaining` never underflows. It is only decremented while greater than 1.
- `enable`=0 in any state:
  - Next cycle the block is in IDLE with IDLE output values.
  - The shift register and counters are cleared.
  - A restart needs a new `control_complete` seen in IDLE.
- `control_complete` or `Tx_request` changing during LOAD or SHIFT is ignored. `enable` is the only abort.

## Timing
- Reset values: state IDLE, `data_bit`=1, `bit_counter`=0, `data_complete`=0, shift register 0, `bits_remaining`=0.
- All outputs are registered.
- Start condition true in cycle N:
  - LOAD in cycle N+1.
  - First data bit valid on `data_bit` in cycle N+2.
- A `sample_point` during LOAD is not counted. The bench keeps at least 2 clocks between `control_complete` and the next `sample_point`.
- The k-th counted `sample_point` in SHIFT, at cycle M:
  - `bit_counter`=k from cycle M+1.
  - The next bit is on `data_bit` from cycle M+1.
- The last counted `sample_point`, at cycle M: `data_complete`=1 and `data_bit`=1 from cycle M+1.
- Zero-length data field (`rtr`=1, or DLC 0): `data_complete`=1 in cycle N+2.
- `Tx_request` low while in COMPLETE at cycle P: IDLE from P+1, `data_complete`=0.
- Start condition held true through COMPLETE→IDLE: a new frame begins one cycle after IDLE is entered.
- `reset_n` assertion mid-frame: all outputs return to reset values immediately, with no clock required.

## Test plan
- DLC=1, `data_in`[63:56]=0xA5, `rtr`=0, sample pulse every 5 clocks:
  - `data_bit` sequence 1,0,1,0,0,1,0,1.
  - `bit_counter` steps 1..8.
  - `data_complete`=1 one cycle after the 8th pulse.
- DLC=0, `rtr`=0: `data_complete`=1 two cycles after the trigger, `bit_counter` stays 0, `data_bit` stays 1.
- DLC=8 and DLC=15, `data_in`=0x0123456789ABCDEF:
  - Exactly 64 bits match `data_in` MSB-first.
  - `bit_counter` ends at 64.
  - Both DLCs give identical output.
- `rtr`=1, DLC=8: no bits shifted, `data_complete` in cycle N+2, `bit_counter`=0.
- DLC=2, `enable` dropped after 5 pulses:
  - Next cycle IDLE, `bit_counter`=0, `data_bit`=1.
  - After re-enable and a new trigger, the full 16-bit payload is sent from bit 0.
- DLC=4, `reset_n` pulsed low after 10 pulses:
  - Outputs are 1/0/0 asynchronously.
  - Drop `Tx_request` while in COMPLETE: IDLE and `data_complete`=0 the next cycle.
